// File: rtl/hsb_line_packetizer.sv
// hsb_line_packetizer
//
// Takes video lines from the MIPI AXIS shim and cuts each line into packets
// of at most C_MAX_BEATS payload beats. Each packet starts with one header beat
// that carries the frame number, the line number and the beat offset of the
// first payload beat within the line.
//
// Header beat layout (m_axis_tuser[0]=1):
//   tdata[15:0]  frame number (zero-extended from C_CNT_W)
//   tdata[31:16] line number
//   tdata[47:32] beat offset within the line
//   tdata[48]    SOF flag of the first input beat of this packet
//   all other bits 0, tkeep all ones, tlast 0
//
// Handshake: a beat moves on an interface in any cycle where tvalid and tready
// are both high at the rising clock edge. m_axis_tvalid never drops and the
// m_axis_* payload never changes while m_axis_tvalid=1 and m_axis_tready=0.
// s_axis_tready depends only on the state and the output register, never on
// s_axis_tvalid.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_axis_*            input line stream (tuser[0]=SOF, tlast=end of line)
//   m_axis_*            packet stream (tuser[0]=header, tuser[1]=end of line,
//                       tlast=last beat of packet)
//   err_sof_midpkt      sticky flag: SOF seen on a payload beat that was not
//                       the first beat of its packet
module hsb_line_packetizer #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_MAX_BEATS        = 256,
  parameter int C_CNT_W            = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [1:0]                      s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [1:0]                      m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            err_sof_midpkt
);

  localparam int W    = C_AXIS_TDATA_WIDTH;
  localparam int KW   = C_AXIS_TDATA_WIDTH / 8;
  localparam int BC_W = (C_MAX_BEATS > 1) ? $clog2(C_MAX_BEATS) : 1;

  localparam logic [BC_W-1:0]    BC_LAST = BC_W'(C_MAX_BEATS - 1);
  localparam logic [BC_W-1:0]    BC_ONE  = BC_W'(1);
  localparam logic [C_CNT_W-1:0] CNT_ONE = C_CNT_W'(1);

  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] frame_q, frame_d;
  logic [C_CNT_W-1:0] line_q, line_d;
  logic [C_CNT_W-1:0] offset_q, offset_d;
  logic [BC_W-1:0]    beat_cnt, beat_cnt_d;
  logic               err_d;

  logic [W-1:0]       tdata_d;
  logic [KW-1:0]      tkeep_d;
  logic [1:0]         tuser_d;
  logic               tlast_d;
  logic               tvalid_d;

  logic               slot_free;
  logic               sof_in;
  logic               hdr_go;
  logic               pay_go;
  logic [C_CNT_W-1:0] hdr_frame;
  logic [C_CNT_W-1:0] hdr_line;
  logic [C_CNT_W-1:0] hdr_offset;
  logic [W-1:0]       hdr_word;

  // s_axis_tuser[1] carries nothing this block needs.
  logic unused_tuser1;
  assign unused_tuser1 = s_axis_tuser[1];

  // The single output register can take a new beat when it is empty or when
  // its current beat leaves in this cycle.
  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_q == ST_PAY) && slot_free;
  assign sof_in        = s_axis_tuser[0];

  // In HDR the input beat is only peeked at (its SOF bit picks the header
  // contents); it is consumed later in PAY.
  assign hdr_go = (state_q == ST_HDR) && s_axis_tvalid && slot_free;
  assign pay_go = s_axis_tvalid && s_axis_tready;

  always_comb begin
    hdr_frame  = sof_in ? (frame_q + CNT_ONE) : frame_q;
    hdr_line   = sof_in ? '0 : line_q;
    hdr_offset = sof_in ? '0 : offset_q;
    hdr_word          = '0;
    hdr_word[15:0]    = 16'(hdr_frame);
    hdr_word[31:16]   = 16'(hdr_line);
    hdr_word[47:32]   = 16'(hdr_offset);
    hdr_word[48]      = sof_in;
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    line_d     = line_q;
    offset_d   = offset_q;
    beat_cnt_d = beat_cnt;
    err_d      = err_sof_midpkt;
    tdata_d    = m_axis_tdata;
    tkeep_d    = m_axis_tkeep;
    tuser_d    = m_axis_tuser;
    tlast_d    = m_axis_tlast;
    // Without a new load the beat either stays (stalled) or leaves.
    tvalid_d   = m_axis_tvalid && !m_axis_tready;

    if (hdr_go) begin
      state_d    = ST_PAY;
      beat_cnt_d = '0;
      tvalid_d   = 1'b1;
      tdata_d    = hdr_word;
      tkeep_d    = '1;
      tuser_d    = 2'b01;
      tlast_d    = 1'b0;
      if (sof_in) begin
        frame_d  = frame_q + CNT_ONE;
        line_d   = '0;
        offset_d = '0;
      end
    end else if (pay_go) begin
      tvalid_d   = 1'b1;
      tdata_d    = s_axis_tdata;
      tkeep_d    = s_axis_tkeep;
      tuser_d    = 2'b00;
      tlast_d    = 1'b0;
      offset_d   = offset_q + CNT_ONE;
      beat_cnt_d = beat_cnt + BC_ONE;
      // SOF is legal only on the beat the header was built from.
      if (sof_in && (beat_cnt != '0)) begin
        err_d = 1'b1;
      end
      // End of line wins over the packet-length limit when both coincide.
      if (s_axis_tlast) begin
        tlast_d  = 1'b1;
        tuser_d  = 2'b10;
        line_d   = line_q + CNT_ONE;
        offset_d = '0;
        state_d  = ST_HDR;
      end else if (beat_cnt == BC_LAST) begin
        tlast_d  = 1'b1;
        state_d  = ST_HDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_HDR;
      frame_q        <= '1;
      line_q         <= '0;
      offset_q       <= '0;
      beat_cnt       <= '0;
      err_sof_midpkt <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tuser   <= '0;
      m_axis_tlast   <= 1'b0;
      m_axis_tvalid  <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      line_q         <= line_d;
      offset_q       <= offset_d;
      beat_cnt       <= beat_cnt_d;
      err_sof_midpkt <= err_d;
      m_axis_tdata   <= tdata_d;
      m_axis_tkeep   <= tkeep_d;
      m_axis_tuser   <= tuser_d;
      m_axis_tlast   <= tlast_d;
      m_axis_tvalid  <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_hsb_line_packetizer.sv
// Directed bench for hsb_line_packetizer with C_MAX_BEATS=4.
// Output beats are packed as {tdata[63:0], tkeep[7:0], tuser[1:0], tlast}.
module tb_hsb_line_packetizer;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int BW = DW + KW + 3;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [1:0]    s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [1:0]    m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          err_sof_midpkt;

  hsb_line_packetizer #(
    .C_AXIS_TDATA_WIDTH(DW),
    .C_MAX_BEATS(4),
    .C_CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .err_sof_midpkt(err_sof_midpkt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int            got_cyc[$];
  int            last_span = 0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] hdr_beat(input logic [15:0] f, input logic [15:0] l,
                                             input logic [15:0] o, input logic sof);
    logic [DW-1:0] d;
    d = {15'd0, sof, o, l, f};
    return {d, 8'hFF, 2'b01, 1'b0};
  endfunction

  function automatic logic [DW-1:0] pay_data(input int tag, input int i);
    return {32'(tag), 32'(i)};
  endfunction

  function automatic logic [KW-1:0] pay_keep(input int i, input int n);
    return (i == n - 1) ? 8'h3F : 8'hFF;
  endfunction

  function automatic logic [BW-1:0] pay_beat(input int tag, input int i, input int n, input logic last_pkt);
    logic eol;
    eol = (i == n - 1);
    return {pay_data(tag, i), pay_keep(i, n), eol, 1'b0, last_pkt};
  endfunction

  // Payload beats [first, first+count) of an n-beat line, closing one packet.
  task automatic exp_pkt(input int tag, input int n, input int first, input int count);
    for (int k = 0; k < count; k++) begin
      exp_q.push_back(pay_beat(tag, first + k, n, (k == count - 1)));
    end
  endtask

  // ---------------- output monitor ----------------
  logic [BW-1:0] cur_beat;
  logic [BW-1:0] stall_beat;
  bit            stall_prev = 1'b0;
  assign cur_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};

  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(cur_beat);
      got_cyc.push_back(cyc);
    end
    if (rst_n && stall_prev) chk("stall_hold", cur_beat, stall_beat);
    stall_prev = rst_n && m_axis_tvalid && !m_axis_tready;
    stall_beat = cur_beat;
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [1:0] u, input logic l);
    bit acc;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    acc = 1'b0;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
    end
    chk("s_handshake", BW'(acc), BW'(1));
  endtask

  // tuser[1] toggles on odd beats to show it is ignored.
  task automatic send_line(input int tag, input int n, input int sof_idx);
    logic [1:0] u;
    for (int i = 0; i < n; i++) begin
      u[1] = (i % 2 == 1);
      u[0] = (i == sof_idx);
      send_beat(pay_data(tag, i), pay_keep(i, n), u, (i == n - 1));
    end
    s_axis_tvalid = 1'b0;
  endtask

  // Waits for every expected beat, allows a few cycles for extra beats, then
  // compares the captured stream against the expected queue.
  task automatic drain(input string tag);
    int n;
    for (int t = 0; t < 3000 && got_q.size() < exp_q.size(); t++) begin
      @(posedge clk);
      #2;
    end
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    chk({tag, "_count"}, BW'(got_q.size()), BW'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, got_q[i], exp_q[i]);
    last_span = (got_cyc.size() > 0) ? (got_cyc[got_cyc.size() - 1] - got_cyc[0]) : -1;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_beat", cur_beat, '0);
    chk("rst_m_tvalid", BW'(m_axis_tvalid), '0);
    chk("rst_s_tready", BW'(s_axis_tready), '0);
    chk("rst_err", BW'(err_sof_midpkt), '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Line before any SOF: frame still all ones.
    exp_q.push_back(hdr_beat(16'hFFFF, 16'd0, 16'd0, 1'b0));
    exp_pkt(1, 3, 0, 3);
    send_line(1, 3, -1);
    drain("t_nosof");

    // SOF frame, 3-beat line, back-to-back output.
    exp_q.push_back(hdr_beat(16'd0, 16'd0, 16'd0, 1'b1));
    exp_pkt(2, 3, 0, 3);
    send_line(2, 3, 0);
    drain("t_sof3");
    chk("t_sof3_span", BW'(last_span), BW'(3));

    // 10-beat line split 4/4/2, then next line restarts offsets.
    exp_q.push_back(hdr_beat(16'd1, 16'd0, 16'd0, 1'b1));
    exp_pkt(3, 10, 0, 4);
    exp_q.push_back(hdr_beat(16'd1, 16'd0, 16'd4, 1'b0));
    exp_pkt(3, 10, 4, 4);
    exp_q.push_back(hdr_beat(16'd1, 16'd0, 16'd8, 1'b0));
    exp_pkt(3, 10, 8, 2);
    exp_q.push_back(hdr_beat(16'd1, 16'd1, 16'd0, 1'b0));
    exp_pkt(4, 2, 0, 2);
    send_line(3, 10, 0);
    send_line(4, 2, -1);
    drain("t_split");

    // Line length equal to the packet limit: EOL wins, then a 1-beat line.
    exp_q.push_back(hdr_beat(16'd1, 16'd2, 16'd0, 1'b0));
    exp_pkt(5, 4, 0, 4);
    exp_q.push_back(hdr_beat(16'd1, 16'd3, 16'd0, 1'b0));
    exp_pkt(6, 1, 0, 1);
    send_line(5, 4, -1);
    send_line(6, 1, -1);
    drain("t_exact");
    chk("t_exact_err", BW'(err_sof_midpkt), '0);

    // SOF on the second payload beat: forwarded, error sticks, frame kept.
    exp_q.push_back(hdr_beat(16'd1, 16'd4, 16'd0, 1'b0));
    exp_pkt(7, 3, 0, 3);
    exp_q.push_back(hdr_beat(16'd1, 16'd5, 16'd0, 1'b0));
    exp_pkt(8, 2, 0, 2);
    send_line(7, 3, 1);
    chk("t_midsof_err", BW'(err_sof_midpkt), BW'(1));
    send_line(8, 2, -1);
    drain("t_midsof");
    chk("t_midsof_err_sticky", BW'(err_sof_midpkt), BW'(1));

    // Random output backpressure: 3 frames x 5 lines x 9 beats.
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 5; l++) begin
        exp_q.push_back(hdr_beat(16'(2 + f), 16'(l), 16'd0, (l == 0)));
        exp_pkt(100 + f * 8 + l, 9, 0, 4);
        exp_q.push_back(hdr_beat(16'(2 + f), 16'(l), 16'd4, 1'b0));
        exp_pkt(100 + f * 8 + l, 9, 4, 4);
        exp_q.push_back(hdr_beat(16'(2 + f), 16'(l), 16'd8, 1'b0));
        exp_pkt(100 + f * 8 + l, 9, 8, 1);
      end
    end
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 5; l++) begin
        send_line(100 + f * 8 + l, 9, (l == 0) ? 0 : -1);
      end
    end
    drain("t_rand");
    rand_ready    = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t_rand_err_sticky", BW'(err_sof_midpkt), BW'(1));

    // Reset in the middle of a line.
    exp_q.push_back(hdr_beat(16'd5, 16'd0, 16'd0, 1'b1));
    exp_q.push_back(pay_beat(20, 0, 6, 1'b0));
    exp_q.push_back(pay_beat(20, 1, 6, 1'b0));
    send_beat(pay_data(20, 0), pay_keep(0, 6), 2'b01, 1'b0);
    send_beat(pay_data(20, 1), pay_keep(1, 6), 2'b10, 1'b0);
    s_axis_tvalid = 1'b0;
    drain("t_pre_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_out_beat", cur_beat, '0);
    chk("mid_rst_m_tvalid", BW'(m_axis_tvalid), '0);
    chk("mid_rst_s_tready", BW'(s_axis_tready), '0);
    chk("mid_rst_err", BW'(err_sof_midpkt), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(hdr_beat(16'hFFFF, 16'd0, 16'd0, 1'b0));
    exp_pkt(21, 2, 0, 2);
    exp_q.push_back(hdr_beat(16'd0, 16'd0, 16'd0, 1'b1));
    exp_pkt(22, 3, 0, 3);
    send_line(21, 2, -1);
    send_line(22, 3, 0);
    drain("t_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
